mult_rr_sched: RTL

Round-robin scheduler that shares one pipelined signed multiplier (`neg_mult`-style, AW×BW → AW+BW) among NREQ requesters. It owns a single multiplier issue slot and accepts at most one operand pair per cycle through per-requester valid/ready handshakes. A tag pipeline tracks each issued operation so the product returns with the ID of its requester. It sits between the requesting datapath blocks and the multiplier instance.

---
 rtl/mult_rr_sched_if.sv | 55 +++++
 rtl/mult_rr_sched.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mult_rr_sched_if.sv
// ----------------------------------------------------------------------------
// mult_rr_sched_if
// Bundle of signals between the requesters, the round-robin multiplier
// scheduler and the shared pipelined multiplier.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b         : packed signed operands, requester i at [i*W +: W]
//   req_neg             : per-requester negate flag (only with MULT_SCHED_NEG_EN)
//   mult_a/mult_b       : registered operands to the multiplier
//   mult_p              : multiplier product, LAT cycles after mult_a/mult_b
//   res_valid/id/prod   : single-cycle result strobe with requester index
// Modports: master = requester/multiplier side, slave = scheduler.
// Optional feature macro: MULT_SCHED_NEG_EN.
// ----------------------------------------------------------------------------
interface mult_rr_sched_if #(
    parameter int AW   = 27,
    parameter int BW   = 24,
    parameter int NREQ = 4
);
    localparam int MW = AW + BW;
    localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_a;
    logic [NREQ*BW-1:0]   req_b;
`ifdef MULT_SCHED_NEG_EN
    logic [NREQ-1:0]      req_neg;
`endif
    logic [AW-1:0]        mult_a;
    logic [BW-1:0]        mult_b;
    logic [MW-1:0]        mult_p;
    logic                 res_valid;
    logic [IW-1:0]        res_id;
    logic [MW-1:0]        res_prod;

`ifdef MULT_SCHED_NEG_EN
    modport master (
        output req_valid, req_a, req_b, req_neg, mult_p,
        input  req_ready, mult_a, mult_b, res_valid, res_id, res_prod
    );
    modport slave (
        input  req_valid, req_a, req_b, req_neg, mult_p,
        output req_ready, mult_a, mult_b, res_valid, res_id, res_prod
    );
`else
    modport master (
        output req_valid, req_a, req_b, mult_p,
        input  req_ready, mult_a, mult_b, res_valid, res_id, res_prod
    );
    modport slave (
        input  req_valid, req_a, req_b, mult_p,
        output req_ready, mult_a, mult_b, res_valid, res_id, res_prod
    );
`endif
endinterface

// File: rtl/mult_rr_sched.sv
// ----------------------------------------------------------------------------
// mult_rr_sched
// Round-robin scheduler sharing one pipelined signed multiplier among NREQ
// requesters. At most one operand pair is issued per cycle; a tag pipe of
// LAT+1 stages follows each issue so the product returns with its requester
// id. Result latency from handshake to res_valid is LAT+2 cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mult_rr_sched_if.slave (request handshakes, multiplier operands
//          and product, result strobe)
// Optional feature macro: MULT_SCHED_NEG_EN -- per-requester req_neg flag
// rides in the tag pipe and negates the returned product.
// ----------------------------------------------------------------------------
module mult_rr_sched #(
    parameter int AW   = 27,
    parameter int BW   = 24,
    parameter int NREQ = 4,
    parameter int LAT  = 3
) (
    input  logic           clk,
    input  logic           rst,
    mult_rr_sched_if.slave bus
);
    localparam int MW = AW + BW;
    localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic [IW-1:0]          ptr_q, ptr_d;
    logic [IW-1:0]          gnt_idx;
    logic                   gnt_any;
    logic [NREQ-1:0]        gnt_oh;
    logic                   hs;

    logic [AW-1:0]          mult_a_q, mult_a_d;
    logic [BW-1:0]          mult_b_q, mult_b_d;

    // Tag pipe: stage 0 lines up with mult_a/mult_b, stage LAT with mult_p.
    logic [LAT:0]           vld_pipe_q;
    logic [LAT:0][IW-1:0]   id_pipe_q;
    logic [IW-1:0]          id_in;
`ifdef MULT_SCHED_NEG_EN
    logic [LAT:0]           neg_pipe_q;
    logic                   neg_in;
`endif

    logic                   res_valid_q;
    logic [IW-1:0]          res_id_q;
    logic [MW-1:0]          res_prod_q, res_prod_d;

    // Search ptr, ptr+1, ... mod NREQ; walking the offsets downwards lets the
    // smallest offset with a valid request be the last (winning) assignment.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (bus.req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
        gnt_oh = '0;
        if (gnt_any && !rst)
            gnt_oh[gnt_idx] = 1'b1;
    end

    assign hs = |(gnt_oh & bus.req_valid);

    always_comb begin
        ptr_d    = ptr_q;
        mult_a_d = mult_a_q;
        mult_b_d = mult_b_q;
        id_in    = '0;
        if (hs) begin
            ptr_d    = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            mult_a_d = bus.req_a[int'(gnt_idx)*AW +: AW];
            mult_b_d = bus.req_b[int'(gnt_idx)*BW +: BW];
            id_in    = gnt_idx;
        end
    end

`ifdef MULT_SCHED_NEG_EN
    assign neg_in     = hs & bus.req_neg[gnt_idx];
    assign res_prod_d = neg_pipe_q[LAT] ? -bus.mult_p : bus.mult_p;
`else
    assign res_prod_d = bus.mult_p;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            mult_a_q    <= '0;
            mult_b_q    <= '0;
            vld_pipe_q  <= '0;
            id_pipe_q   <= '0;
`ifdef MULT_SCHED_NEG_EN
            neg_pipe_q  <= '0;
`endif
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_prod_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            mult_a_q    <= mult_a_d;
            mult_b_q    <= mult_b_d;
            vld_pipe_q  <= {vld_pipe_q[LAT-1:0], hs};
            id_pipe_q   <= {id_pipe_q[LAT-1:0], id_in};
`ifdef MULT_SCHED_NEG_EN
            neg_pipe_q  <= {neg_pipe_q[LAT-1:0], neg_in};
`endif
            res_valid_q <= vld_pipe_q[LAT];
            // id/prod hold between results so downstream sees stable values.
            if (vld_pipe_q[LAT]) begin
                res_id_q   <= id_pipe_q[LAT];
                res_prod_q <= res_prod_d;
            end
        end
    end

    assign bus.req_ready = gnt_oh;
    assign bus.mult_a    = mult_a_q;
    assign bus.mult_b    = mult_b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_prod  = res_prod_q;

endmodule
